// File: rtl/bufgce_div_seq.sv
// bufgce_div_seq: glitch-safe ratio-change sequencer for a bank of BUFGCE_DIV dividers
module bufgce_div_seq #(
    parameter int NUM_BUF       = 4,
    parameter int DEFAULT_SEL   = 0,
    parameter int CE_LAT        = 3,
    parameter int MAX_DIVIDE    = 8,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       REQ_VALID,
    input  logic [2:0]                 REQ_SEL,
    output logic                       REQ_READY,
    output logic [NUM_BUF-1:0]         CE,
    output logic [NUM_BUF-1:0]         CLR,
    output logic [$clog2(NUM_BUF)-1:0] SEL,
    output logic                       LOCKED,
    output logic                       ACK,
    output logic                       ERR
);
    localparam int SW = $clog2(NUM_BUF);
    localparam int G  = CE_LAT + MAX_DIVIDE;
    localparam int M1 = G > CLR_CYCLES ? G : CLR_CYCLES;
    localparam int MW = M1 > SETTLE_CYCLES ? M1 : SETTLE_CYCLES;
    localparam int CW = $clog2(MW) + 1;

    typedef enum logic [2:0] {INIT_CLR, IDLE, GATE, SWITCH, CLEAR, SETTLE, DONE} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [SW-1:0]      tgt, tgt_n, sel_n;
    logic               from_req, from_req_n;
    logic [NUM_BUF-1:0] ce_n, clr_n, tgt_oh;
    logic               ready_n, locked_n, ack_n, err_n, last;

    assign last   = cnt == '0;
    assign tgt_oh = NUM_BUF'(1) << tgt;

    // state and registered outputs; async reset forces the safe all-cleared state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= INIT_CLR;
            cnt       <= CW'(CLR_CYCLES - 1);
            tgt       <= SW'(DEFAULT_SEL);
            from_req  <= 1'b0;
            CE        <= '0;
            CLR       <= '1;
            SEL       <= SW'(DEFAULT_SEL);
            LOCKED    <= 1'b0;
            REQ_READY <= 1'b0;
            ACK       <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tgt       <= tgt_n;
            from_req  <= from_req_n;
            CE        <= ce_n;
            CLR       <= clr_n;
            SEL       <= sel_n;
            LOCKED    <= locked_n;
            REQ_READY <= ready_n;
            ACK       <= ack_n;
            ERR       <= err_n;
        end
    end

    // next-state and next-output logic; the clear phase (init or switch) ends by enabling tgt
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        tgt_n      = tgt;
        from_req_n = from_req;
        ce_n       = CE;
        clr_n      = CLR;
        sel_n      = SEL;
        locked_n   = LOCKED;
        ready_n    = REQ_READY;
        ack_n      = ACK;
        err_n      = ERR;
        case (state)
            INIT_CLR, SWITCH, CLEAR: begin
                if (last) begin
                    clr_n   = '0;
                    ce_n    = tgt_oh;
                    cnt_n   = CW'(SETTLE_CYCLES - 1);
                    state_n = SETTLE;
                end else begin
                    cnt_n   = cnt - CW'(1);
                    state_n = state == SWITCH ? CLEAR : state;
                end
            end
            IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    ready_n = 1'b0;
                    if (32'(REQ_SEL) >= NUM_BUF) begin
                        ack_n   = 1'b1;
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else if (REQ_SEL[SW-1:0] == SEL) begin
                        ack_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        tgt_n      = REQ_SEL[SW-1:0];
                        ce_n       = '0;
                        locked_n   = 1'b0;
                        from_req_n = 1'b1;
                        cnt_n      = CW'(G - 1);
                        state_n    = GATE;
                    end
                end
            end
            GATE: begin
                if (last) begin
                    sel_n   = tgt;
                    clr_n   = tgt_oh;
                    cnt_n   = CW'(CLR_CYCLES - 1);
                    state_n = SWITCH;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            SETTLE: begin
                if (last) begin
                    locked_n = 1'b1;
                    ack_n    = from_req;
                    ready_n  = !from_req;
                    state_n  = from_req ? DONE : IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DONE: begin
                ack_n   = 1'b0;
                err_n   = 1'b0;
                ready_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = INIT_CLR;
        endcase
    end
endmodule

// File: tb/tb_bufgce_div_seq.sv
// tb_bufgce_div_seq: randomized scoreboard bench with a timeline reference model
module tb_bufgce_div_seq;
    localparam int N = 4, DEF = 0, G = 11, C = 2, S = 8;

    logic       CLK = 1'b0, RST_N = 1'b0, REQ_VALID = 1'b0;
    logic [2:0] REQ_SEL = '0;
    logic       REQ_READY, LOCKED, ACK, ERR;
    logic [3:0] CE, CLR;
    logic [1:0] SEL;

    bufgce_div_seq dut (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_SEL(REQ_SEL),
        .REQ_READY(REQ_READY), .CE(CE), .CLR(CLR), .SEL(SEL),
        .LOCKED(LOCKED), .ACK(ACK), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         ack_at;
        logic       err;
        logic [1:0] sel;
    } exp_t;

    exp_t       q[$];
    int         compared = 0, mismatched = 0;
    bit         mode_rst = 1'b1;
    int         base = 0, hs_e = -1, ready_at = 1 << 30;
    logic [1:0] old_sel = DEF, new_sel = DEF, cur_sel = DEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    // expected outputs as a function of cycles elapsed since reset release or since the accepted switch
    task automatic model(input int c, output logic [3:0] ce, output logic [3:0] clr,
                         output logic [1:0] sel, output logic lk);
        int d;
        d = c - base;
        if (mode_rst) begin
            sel = 2'(DEF);
            ce  = d < C ? 4'b0 : oh(2'(DEF));
            clr = d < C ? 4'hf : 4'b0;
            lk  = d >= C + S;
        end else begin
            sel = d < G ? old_sel : new_sel;
            ce  = d < 0 ? oh(old_sel) : (d < G + C ? 4'b0 : oh(new_sel));
            clr = (d >= G && d < G + C) ? oh(new_sel) : 4'b0;
            lk  = d < 0 || d >= G + C + S;
        end
    endtask

    function automatic bit mready(input int c);
        return c < hs_e || c >= ready_at;
    endfunction

    // scoreboard entry for a request accepted at edge e
    task automatic accept(input int e, input logic [2:0] s);
        hs_e = e;
        if (s >= 3'(N)) begin
            q.push_back('{e, 1'b1, cur_sel});
            ready_at = e + 1;
        end else if (s[1:0] == cur_sel) begin
            q.push_back('{e, 1'b0, cur_sel});
            ready_at = e + 1;
        end else begin
            mode_rst = 1'b0;
            base     = e;
            old_sel  = cur_sel;
            new_sel  = s[1:0];
            cur_sel  = s[1:0];
            q.push_back('{e + G + C + S, 1'b0, s[1:0]});
            ready_at = e + G + C + S + 1;
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] s);
        @(posedge CLK);
        #2;
        REQ_VALID = v;
        REQ_SEL   = s;
        if (v && RST_N && mready(cyc)) accept(cyc + 1, s);
    endtask

    task automatic req(input logic [2:0] s, output int e);
        for (int n = 0; n < 100; n++) begin
            @(posedge CLK);
            #2;
            if (mready(cyc)) begin
                REQ_VALID = 1'b1;
                REQ_SEL   = s;
                e = cyc + 1;
                accept(e, s);
                break;
            end
            REQ_VALID = 1'b0;
        end
        @(posedge CLK);
        #2;
        REQ_VALID = 1'b0;
    endtask

    task automatic release_rst();
        RST_N    = 1'b1;
        mode_rst = 1'b1;
        base     = cyc;
        hs_e     = -1;
        ready_at = cyc + C + S;
        cur_sel  = 2'(DEF);
        old_sel  = 2'(DEF);
        new_sel  = 2'(DEF);
    endtask

    logic [3:0] pce;
    logic [1:0] psel;
    logic       prst = 1'b0;

    // monitor: compare every cycle against the model, pop the scoreboard on ACK, check invariants
    always @(negedge CLK) begin
        logic [3:0] ece, eclr;
        logic [1:0] esel;
        logic       elk, eack;
        if (!RST_N) begin
            chk("rst_CE", CE, 4'b0);
            chk("rst_CLR", CLR, 4'hf);
            chk("rst_SEL", SEL, DEF);
            chk("rst_LOCKED", LOCKED, 0);
            chk("rst_READY", REQ_READY, 0);
            chk("rst_ACK", ACK, 0);
        end else begin
            model(cyc, ece, eclr, esel, elk);
            chk("CE", CE, ece);
            chk("CLR", CLR, eclr);
            chk("SEL", SEL, esel);
            chk("LOCKED", LOCKED, elk);
            chk("REQ_READY", REQ_READY, mready(cyc));
            eack = q.size() > 0 && q[0].ack_at == cyc;
            chk("ACK", ACK, eack);
            if (eack) begin
                if (ACK) begin
                    chk("ERR", ERR, q[0].err);
                    chk("ACK_SEL", SEL, q[0].sel);
                end
                void'(q.pop_front());
            end
            chk("CE_onehot0", $onehot0(CE), 1);
            chk("CE_CLR_overlap", CE & CLR, 0);
            if (prst && SEL != psel) chk("SEL_change_gated", {pce, CE}, 0);
        end
        pce  = CE;
        psel = SEL;
        prst = RST_N;
    end

    initial begin
        int e;
        repeat (3) @(posedge CLK);
        #2;
        release_rst();
        req(3'd2, e);
        req(3'd5, e);
        req(3'd2, e);
        req(3'd1, e);
        repeat (12) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        q.delete();
        chk("async_CE", CE, 4'b0);
        chk("async_CLR", CLR, 4'hf);
        chk("async_SEL", SEL, DEF);
        chk("async_LOCKED", LOCKED, 0);
        repeat (3) @(posedge CLK);
        #2;
        release_rst();
        for (int i = 0; i < 700; i++) drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
        @(posedge CLK);
        #2;
        REQ_VALID = 1'b0;
        repeat (G + C + S + 5) @(posedge CLK);
        #2;
        chk("pending_acks", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
